// File: rtl/seg7_scan_display_if.sv
// Signal bundle between a counter source and the 4-digit scanned 7-segment display.
// The master side supplies the two counter values and display controls;
// the slave side (the display block) returns the pin drives and status.
interface seg7_scan_display_if;
   logic [13:0] cntr_a;
   logic [13:0] cntr_b;
   logic        sel;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        ovf;
   logic        busy;

   modport master (
      output cntr_a,
      output cntr_b,
      output sel,
      output blank_lz,
      input  seg,
      input  an,
      input  ovf,
      input  busy
   );

   modport slave (
      input  cntr_a,
      input  cntr_b,
      input  sel,
      input  blank_lz,
      output seg,
      output an,
      output ovf,
      output busy
   );
endinterface

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment display driver.
// A scan timer lights one digit for DIGIT_PERIOD cycles in turn. Once per frame
// the selected binary counter is sampled and converted to BCD by a serial
// double-dabble engine; the result is committed atomically so the display
// never shows a half-converted value. Values above 9999 show four dashes.
module seg7_scan_display #(
   parameter int DIGIT_PERIOD = 20,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                 clk_10k,
   input  logic                 rst,
   seg7_scan_display_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [9:0] TIMER_LAST = 10'(DIGIT_PERIOD - 1);
   localparam logic [3:0] SHIFT_LAST = 4'd13;
   localparam logic [6:0] SEG_DASH   = 7'h40;
   localparam logic [6:0] SEG_BLANK  = 7'h00;
   localparam logic [6:0] SEG_ZERO   = 7'h3F;

   logic [9:0]  timer;
   logic [1:0]  digit_idx;
   logic        timer_tc;
   logic [1:0]  digit_nxt;

   state_t      state;
   logic [13:0] bin_sr;
   logic [15:0] scratch;
   logic [15:0] scratch_adj;
   logic [3:0]  shift_cnt;
   logic        ovf_pend;
   logic [15:0] bcd_q;
   logic        ovf_q;
   logic        busy_q;

   logic [6:0]  seg_q;
   logic [3:0]  an_q;
   logic [6:0]  seg_nxt;
   logic [3:0]  nibble;
   logic        blank_digit;
   logic        zero_from3;
   logic        zero_from2;
   logic        zero_from1;

   // Double-dabble correction: a nibble of 5 or more would exceed 9 after doubling.
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // Active-high gfedcba patterns for decimal digits.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

   assign timer_tc  = (timer == TIMER_LAST);
   assign digit_nxt = timer_tc ? digit_idx + 2'd1 : digit_idx;

   assign scratch_adj = {add3(scratch[15:12]), add3(scratch[11:8]),
                         add3(scratch[7:4]),   add3(scratch[3:0])};

   // Scan timer and digit index: advance to the next digit at each terminal count.
   always_ff @(posedge clk_10k or posedge rst) begin
      if (rst) begin
         timer     <= '0;
         digit_idx <= '0;
      end else if (timer_tc) begin
         timer     <= '0;
         digit_idx <= digit_nxt;
      end else begin
         timer     <= timer + 10'd1;
      end
   end

   // Conversion FSM: sample at frame end, shift 14 times, then commit in one cycle.
   always_ff @(posedge clk_10k or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bin_sr    <= '0;
         scratch   <= '0;
         shift_cnt <= '0;
         ovf_pend  <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (timer_tc && (digit_idx == 2'd3)) begin
                  bin_sr    <= bus.sel ? bus.cntr_b : bus.cntr_a;
                  ovf_pend  <= (bus.sel ? bus.cntr_b : bus.cntr_a) > 14'd9999;
                  scratch   <= '0;
                  shift_cnt <= '0;
                  busy_q    <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               scratch   <= {scratch_adj[14:0], bin_sr[13]};
               bin_sr    <= {bin_sr[12:0], 1'b0};
               shift_cnt <= shift_cnt + 4'd1;
               if (shift_cnt == SHIFT_LAST) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               bcd_q  <= scratch;
               ovf_q  <= ovf_pend;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign zero_from3 = (bcd_q[15:12] == 4'd0);
   assign zero_from2 = zero_from3 && (bcd_q[11:8] == 4'd0);
   assign zero_from1 = zero_from2 && (bcd_q[7:4] == 4'd0);

   // Pick the pattern for the digit that will be lit next cycle, applying dash and blanking rules.
   always_comb begin
      nibble      = bcd_q[3:0];
      blank_digit = 1'b0;
      case (digit_nxt)
         2'd0: begin
            nibble      = bcd_q[3:0];
            blank_digit = 1'b0;
         end
         2'd1: begin
            nibble      = bcd_q[7:4];
            blank_digit = zero_from1;
         end
         2'd2: begin
            nibble      = bcd_q[11:8];
            blank_digit = zero_from2;
         end
         default: begin
            nibble      = bcd_q[15:12];
            blank_digit = zero_from3;
         end
      endcase
      if (ovf_q) begin
         seg_nxt = SEG_DASH;
      end else if (bus.blank_lz && blank_digit) begin
         seg_nxt = SEG_BLANK;
      end else begin
         seg_nxt = seg_decode(nibble);
      end
   end

   // Output registers, updated in step with the digit index so seg and an never disagree.
   always_ff @(posedge clk_10k or posedge rst) begin
      if (rst) begin
         an_q  <= 4'b0001;
         seg_q <= SEG_ZERO;
      end else begin
         an_q  <= 4'b0001 << digit_nxt;
         seg_q <= seg_nxt;
      end
   end

   assign bus.seg  = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
   assign bus.an   = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
   assign bus.ovf  = ovf_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed self-checking bench for seg7_scan_display (DIGIT_PERIOD=20, active-low pins).
// A bench-side edge counter, cleared by reset, locates every digit slot and
// frame-end sample point; expected patterns are hand-computed constants.
module tb_seg7_scan_display;

   logic clk_10k = 1'b0;
   logic rst     = 1'b1;
   int   edge_count;
   int   vectors     = 0;
   int   miscompares = 0;

   seg7_scan_display_if bus ();

   seg7_scan_display #(
      .DIGIT_PERIOD(20),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk_10k(clk_10k),
      .rst    (rst),
      .bus    (bus)
   );

   // Free-running bench clock.
   always #5 clk_10k = ~clk_10k;

   // Count rising edges since the last reset release.
   always @(posedge clk_10k or posedge rst) begin
      if (rst) edge_count <= 0;
      else     edge_count <= edge_count + 1;
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Park on the falling edge that follows rising edge k.
   task automatic wait_edge(input int k);
      while (edge_count < k) @(negedge clk_10k);
   endtask

   task automatic check_at(input string tag, input int k, input int idx, input logic [6:0] exp_seg);
      logic [3:0] an_l;
      logic [6:0] seg_l;
      logic [3:0] exp_an;
      wait_edge(k);
      an_l   = ~bus.an;
      seg_l  = ~bus.seg;
      exp_an = 4'b0001 << idx;
      check_output({tag, "_an"},  {28'd0, an_l},  {28'd0, exp_an});
      check_output({tag, "_seg"}, {25'd0, seg_l}, {25'd0, exp_seg});
   endtask

   // Check all four digits of the frame starting at edge base; exp is {d3,d2,d1,d0}.
   task automatic check_frame(input string tag, input int base, input logic [27:0] exp);
      check_at($sformatf("%s_d0", tag), base + 18, 0, exp[6:0]);
      check_at($sformatf("%s_d1", tag), base + 30, 1, exp[13:7]);
      check_at($sformatf("%s_d2", tag), base + 50, 2, exp[20:14]);
      check_at($sformatf("%s_d3", tag), base + 70, 3, exp[27:21]);
   endtask

   task automatic check_bit(input string tag, input int k, input logic observed_sel, input logic expected);
      logic v;
      wait_edge(k);
      v = observed_sel ? bus.ovf : bus.busy;
      check_output(tag, {31'd0, v}, {31'd0, expected});
   endtask

   task automatic check_reset_state(input string tag);
      logic [3:0] an_l;
      logic [6:0] seg_l;
      an_l  = ~bus.an;
      seg_l = ~bus.seg;
      check_output({tag, "_an"},   {28'd0, an_l},     32'h1);
      check_output({tag, "_seg"},  {25'd0, seg_l},    32'h3F);
      check_output({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check_output({tag, "_ovf"},  {31'd0, bus.ovf},  32'd0);
   endtask

   task automatic apply_stimulus(input logic [13:0] a, input logic [13:0] b, input logic s, input logic blz);
      bus.cntr_a   = a;
      bus.cntr_b   = b;
      bus.sel      = s;
      bus.blank_lz = blz;
   endtask

   initial begin
      apply_stimulus(14'd1234, 14'd0, 1'b0, 1'b1);
      #23;
      @(negedge clk_10k);
      check_reset_state("reset");
      rst = 1'b0;

      // Scan rotation and timing, display shows reset value 0 blanked to '   0'.
      check_at("scan_d0",      10, 0, 7'h3F);
      check_at("scan_d0_last", 19, 0, 7'h3F);
      check_at("scan_d1_first",20, 1, 7'h00);
      check_at("scan_d1",      30, 1, 7'h00);
      check_at("scan_d2",      50, 2, 7'h00);
      check_at("scan_d3",      70, 3, 7'h00);
      check_at("scan_d3_last", 79, 3, 7'h00);
      check_bit("busy_idle", 79, 1'b0, 1'b0);
      check_bit("busy_start", 80, 1'b0, 1'b1);
      check_at("frame_wrap",   80, 0, 7'h3F);
      check_at("precommit",    90, 0, 7'h3F);
      check_bit("busy_commit", 94, 1'b0, 1'b1);
      check_bit("busy_done",   95, 1'b0, 1'b0);
      check_frame("val1234", 80, {7'h06, 7'h5B, 7'h4F, 7'h66});

      wait_edge(155);
      apply_stimulus(14'd7, 14'd0, 1'b0, 1'b1);
      check_frame("blank_on", 160, {7'h00, 7'h00, 7'h00, 7'h07});

      wait_edge(240);
      apply_stimulus(14'd7, 14'd0, 1'b0, 1'b0);
      check_frame("blank_off", 240, {7'h3F, 7'h3F, 7'h3F, 7'h07});

      wait_edge(315);
      apply_stimulus(14'd7, 14'd9999, 1'b1, 1'b0);
      check_frame("max9999", 320, {7'h6F, 7'h6F, 7'h6F, 7'h6F});
      check_bit("ovf_9999", 390, 1'b1, 1'b0);

      wait_edge(395);
      apply_stimulus(14'd7, 14'd10000, 1'b1, 1'b1);
      check_bit("ovf_before_commit", 414, 1'b1, 1'b0);
      check_bit("ovf_10000",         416, 1'b1, 1'b1);
      check_frame("dash", 400, {7'h40, 7'h40, 7'h40, 7'h40});

      wait_edge(475);
      apply_stimulus(14'd4321, 14'd55, 1'b0, 1'b1);
      wait_edge(483);
      apply_stimulus(14'd4321, 14'd55, 1'b1, 1'b1);
      check_bit("ovf_cleared", 496, 1'b1, 1'b0);
      check_frame("iso_first", 480, {7'h66, 7'h4F, 7'h5B, 7'h06});
      check_frame("iso_next",  560, {7'h00, 7'h00, 7'h6D, 7'h6D});

      wait_edge(635);
      apply_stimulus(14'd1234, 14'd55, 1'b0, 1'b1);
      check_frame("pre_abort", 640, {7'h06, 7'h5B, 7'h4F, 7'h66});
      wait_edge(715);
      apply_stimulus(14'd9876, 14'd55, 1'b0, 1'b1);
      check_bit("busy_mid_shift", 724, 1'b0, 1'b1);
      wait_edge(725);
      rst = 1'b1;
      #1;
      check_reset_state("abort");
      repeat (3) @(negedge clk_10k);
      rst = 1'b0;

      check_frame("post_reset", 0, {7'h00, 7'h00, 7'h00, 7'h3F});
      check_bit("busy_post_idle",  79, 1'b0, 1'b0);
      check_bit("busy_post_start", 80, 1'b0, 1'b1);
      check_frame("first_after_reset", 80, {7'h6F, 7'h7F, 7'h07, 7'h7D});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
